// File: rtl/sdram_read_arbiter.sv
// sdram_read_arbiter
// Shares one 64-bit Avalon-MM SDRAM read port between two read masters.
// Port 0 (frame-buffer scanout) has fixed priority; port 1 (secondary reader)
// is promoted once it has been refused STARVE_LIMIT consecutive cycles.
// Every accepted command pushes a tag {owner, words} into a FIFO, and returned
// words are steered to the master named by the head tag, in command order.
//
// Ports:
//   clock, reset_n            system clock, asynchronous active-low reset
//   mN_address/burstcount     command from master N (burstcount 0 means 1)
//   mN_read / mN_waitrequest  Avalon command handshake for master N
//   mN_readdata/datavalid     returned word and its steering strobe
//   s_*                       SDRAM-side Avalon read port
//   outstanding               tag FIFO occupancy
//   error                     sticky: a word came back with no outstanding tag
//
// Handshake: a command transfers in the cycle where s_read is high and
// s_waitrequest is low. Master N's command transfers in the same cycle, seen
// as mN_read high with mN_waitrequest low. A master keeps mN_read and its
// command fields stable until that cycle.
module sdram_read_arbiter #(
  parameter int MAX_OUTSTANDING  = 16,
  parameter int OUTSTANDING_LOG2 = 4,
  parameter int STARVE_LIMIT     = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [28:0]               m0_address,
  input  logic [7:0]                m0_burstcount,
  input  logic                      m0_read,
  output logic                      m0_waitrequest,
  output logic [63:0]               m0_readdata,
  output logic                      m0_readdatavalid,
  input  logic [28:0]               m1_address,
  input  logic [7:0]                m1_burstcount,
  input  logic                      m1_read,
  output logic                      m1_waitrequest,
  output logic [63:0]               m1_readdata,
  output logic                      m1_readdatavalid,
  output logic [28:0]               s_address,
  output logic [7:0]                s_burstcount,
  output logic                      s_read,
  input  logic                      s_waitrequest,
  input  logic [63:0]               s_readdata,
  input  logic                      s_readdatavalid,
  output logic [OUTSTANDING_LOG2:0] outstanding,
  output logic                      error
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [OUTSTANDING_LOG2:0] FULL_CNT = (OUTSTANDING_LOG2 + 1)'(MAX_OUTSTANDING);

  // A stalled command keeps its owner until it transfers (address stability).
  typedef enum logic {ARB_OPEN, ARB_LOCKED} arb_state_t;

  arb_state_t                  arb_state;
  logic                        lock_owner;
  logic [SW-1:0]               starve_cnt;
  logic                        owner_valid;
  logic                        owner;
  logic                        owner_read;
  logic                        accept;
  logic                        tag_full;
  logic                        tag_empty;
  logic [8:0]                  tag_mem [MAX_OUTSTANDING];
  logic [OUTSTANDING_LOG2-1:0] wr_ptr;
  logic [OUTSTANDING_LOG2-1:0] rd_ptr;
  logic [OUTSTANDING_LOG2:0]   count;
  logic [7:0]                  word_cnt;
  logic [8:0]                  head_tag;
  logic [8:0]                  push_tag;
  logic                        beat;
  logic                        pop;

  always_comb begin
    owner_valid = 1'b1;
    owner       = 1'b0;
    if (arb_state == ARB_LOCKED) begin
      owner = lock_owner;
    end else if (starve_cnt == STARVE_MAX && m1_read) begin
      owner = 1'b1;
    end else if (m0_read) begin
      owner = 1'b0;
    end else if (m1_read) begin
      owner = 1'b1;
    end else begin
      owner_valid = 1'b0;
    end
  end

  assign owner_read   = owner ? m1_read : m0_read;
  assign tag_full     = (count == FULL_CNT);
  assign tag_empty    = (count == '0);

  // With no owner, owner is 0, so the command fields idle at port 0's values.
  // reset_n gates s_read so reset kills a presented command immediately.
  assign s_address    = owner ? m1_address : m0_address;
  assign s_burstcount = owner ? m1_burstcount : m0_burstcount;
  assign s_read       = reset_n && owner_valid && owner_read && !tag_full;
  assign accept       = s_read && !s_waitrequest;

  assign m0_waitrequest = !(accept && !owner);
  assign m1_waitrequest = !(accept && owner);

  assign push_tag = {owner, (s_burstcount == 8'd0) ? 8'd1 : s_burstcount};
  assign head_tag = tag_mem[rd_ptr];

  // Return path: steer each word by the head tag; the last word of the head
  // burst retires the tag.
  assign beat = s_readdatavalid && !tag_empty;
  assign pop  = beat && (word_cnt == head_tag[7:0] - 8'd1);

  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = beat && !head_tag[8];
  assign m1_readdatavalid = beat && head_tag[8];
  assign outstanding      = count;

  always_ff @(posedge clock) begin
    if (accept) begin
      tag_mem[wr_ptr] <= push_tag;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      arb_state  <= ARB_OPEN;
      lock_owner <= 1'b0;
      starve_cnt <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      word_cnt   <= '0;
      error      <= 1'b0;
    end else begin
      case (arb_state)
        ARB_OPEN: begin
          if (s_read && s_waitrequest) begin
            arb_state  <= ARB_LOCKED;
            lock_owner <= owner;
          end
        end
        ARB_LOCKED: begin
          if (accept) begin
            arb_state <= ARB_OPEN;
          end
        end
        default: arb_state <= ARB_OPEN;
      endcase

      if (m1_read && !(accept && owner)) begin
        if (starve_cnt != STARVE_MAX) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end else begin
        starve_cnt <= '0;
      end

      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (accept && !pop) begin
        count <= count + 1'b1;
      end else if (!accept && pop) begin
        count <= count - 1'b1;
      end

      if (beat) begin
        word_cnt <= pop ? 8'd0 : word_cnt + 8'd1;
      end

      if (s_readdatavalid && tag_empty) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Testbench for sdram_read_arbiter: randomized masters and SDRAM slave,
// checked every cycle against a queue-based reference model, plus directed
// phases for streaming, starvation, lock, bursts, full FIFO, error and reset.
module tb_sdram_read_arbiter;

  localparam int DEPTH = 16;
  localparam int LIMIT = 8;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [28:0] m0_address, m1_address, s_address;
  logic [7:0]  m0_burstcount, m1_burstcount, s_burstcount;
  logic        m0_read, m1_read, s_read;
  logic        m0_waitrequest, m1_waitrequest, s_waitrequest;
  logic [63:0] m0_readdata, m1_readdata, s_readdata;
  logic        m0_readdatavalid, m1_readdatavalid, s_readdatavalid;
  logic [4:0]  outstanding;
  logic        error;

  sdram_read_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .m0_address(m0_address), .m0_burstcount(m0_burstcount), .m0_read(m0_read),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_burstcount(m1_burstcount), .m1_read(m1_read),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_burstcount(s_burstcount), .s_read(s_read),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .outstanding(outstanding), .error(error)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // stimulus knobs
  int quota [2];
  int p_req [2];
  int bc_fix[2];
  int p_wait, p_ret, lat_fix, wait_hold;
  bit hold_ret, inject_err, ret_now;
  bit          req_on  [2];
  logic [28:0] req_addr[2];
  logic [7:0]  req_bc  [2];

  // reference model: one entry per outstanding command {owner, words left}
  logic [8:0] exp_q[$];
  int         ready_q[$];   // release cycle of each word the slave owes
  int         pend;         // owner of a stalled command, -1 if none
  int         starve;       // consecutive cycles port 1 was refused
  bit         err;

  // last sampled DUT outputs, for directed phases
  logic        obs_sread, obs_w0, obs_w1, obs_rdv0, obs_rdv1, obs_err;
  logic [28:0] obs_addr;
  logic [4:0]  obs_out;

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ---------------- drivers ----------------
  task automatic drive_inputs();
    for (int n = 0; n < 2; n++) begin
      if (!req_on[n] && quota[n] != 0 && int'($urandom_range(0, 99)) < p_req[n]) begin
        req_on[n]   = 1'b1;
        req_addr[n] = 29'($urandom());
        req_bc[n]   = (bc_fix[n] >= 0) ? 8'(bc_fix[n]) : 8'($urandom_range(0, 4));
        if (quota[n] > 0) quota[n]--;
      end
    end
    m0_read       = req_on[0];
    m0_address    = req_on[0] ? req_addr[0] : 29'($urandom());
    m0_burstcount = req_on[0] ? req_bc[0] : 8'($urandom());
    m1_read       = req_on[1];
    m1_address    = req_on[1] ? req_addr[1] : 29'($urandom());
    m1_burstcount = req_on[1] ? req_bc[1] : 8'($urandom());
    if (wait_hold > 0) begin
      s_waitrequest = 1'b1;
      wait_hold--;
    end else begin
      s_waitrequest = int'($urandom_range(0, 99)) < p_wait;
    end
    ret_now = !hold_ret && ready_q.size() > 0 && ready_q[0] <= cyc
              && int'($urandom_range(0, 99)) < p_ret;
    s_readdatavalid = ret_now || inject_err;
    s_readdata      = {$urandom(), $urandom()};
  endtask

  // ---------------- model + per-cycle scoreboard ----------------
  task automatic check_cycle();
    int          own, words, lat;
    bit          full, e_sread, e_acc, e_rdv0, e_rdv1;
    logic [28:0] e_addr;
    logic [7:0]  e_bc;
    logic [8:0]  head;
    full = (exp_q.size() == DEPTH);
    head = (exp_q.size() > 0) ? exp_q[0] : 9'd0;
    own  = -1;
    if (pend >= 0)                     own = pend;
    else if (starve >= LIMIT && m1_read) own = 1;
    else if (m0_read)                  own = 0;
    else if (m1_read)                  own = 1;
    e_sread = (own >= 0) && !full;
    e_acc   = e_sread && !s_waitrequest;
    e_addr  = (own == 1) ? m1_address : m0_address;
    e_bc    = (own == 1) ? m1_burstcount : m0_burstcount;
    e_rdv0  = s_readdatavalid && exp_q.size() > 0 && head[8] == 1'b0;
    e_rdv1  = s_readdatavalid && exp_q.size() > 0 && head[8] == 1'b1;

    check_eq("s_read", 64'(s_read), 64'(e_sread));
    check_eq("s_address", 64'(s_address), 64'(e_addr));
    check_eq("s_burstcount", 64'(s_burstcount), 64'(e_bc));
    check_eq("m0_waitrequest", 64'(m0_waitrequest), 64'(!(e_acc && own == 0)));
    check_eq("m1_waitrequest", 64'(m1_waitrequest), 64'(!(e_acc && own == 1)));
    check_eq("m0_readdatavalid", 64'(m0_readdatavalid), 64'(e_rdv0));
    check_eq("m1_readdatavalid", 64'(m1_readdatavalid), 64'(e_rdv1));
    check_eq("m0_readdata", m0_readdata, s_readdata);
    check_eq("m1_readdata", m1_readdata, s_readdata);
    check_eq("outstanding", 64'(outstanding), 64'(exp_q.size()));
    check_eq("error", 64'(error), 64'(err));

    obs_sread = s_read;   obs_w0 = m0_waitrequest;     obs_w1 = m1_waitrequest;
    obs_rdv0  = m0_readdatavalid; obs_rdv1 = m1_readdatavalid;
    obs_err   = error;    obs_addr = s_address;        obs_out = outstanding;

    // advance the model to the next clock edge
    if (s_readdatavalid) begin
      if (ret_now) void'(ready_q.pop_front());
      if (exp_q.size() == 0) err = 1'b1;
      else if (head[7:0] == 8'd1) void'(exp_q.pop_front());
      else exp_q[0] = head - 9'd1;
    end
    if (e_sread && s_waitrequest) pend = own;
    else if (e_acc) pend = -1;
    if (m1_read && !(e_acc && own == 1)) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
    else starve = 0;
    if (e_acc) begin
      words = (e_bc == 8'd0) ? 1 : int'(e_bc);
      lat   = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 6));
      exp_q.push_back({1'(own), 8'(words)});
      for (int k = 0; k < words; k++) ready_q.push_back(cyc + lat);
      req_on[own] = 1'b0;
    end
  endtask

  task automatic step();
    drive_inputs();
    @(negedge clock);
    check_cycle();
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int k = 0;
    quota[0] = 0; quota[1] = 0; hold_ret = 0; p_ret = 100; p_wait = 0; inject_err = 0;
    while ((req_on[0] || req_on[1] || exp_q.size() > 0 || ready_q.size() > 0) && k < budget) begin
      step();
      k++;
    end
    check_eq(tag, 64'(k < budget), 64'(1));
    step();
  endtask

  task automatic wait_accept(input int n, input string tag);
    int k = 0;
    while ((req_on[n] || quota[n] != 0) && k < 50) begin
      step();
      k++;
    end
    check_eq(tag, 64'(k < 50), 64'(1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          cnt0, cnt1, peak, got, k;
    bit          seq[27];
    logic [28:0] a1;

    quota = '{0, 0}; p_req = '{100, 100}; bc_fix = '{1, 1};
    p_wait = 0; p_ret = 100; lat_fix = 1; wait_hold = 0;
    hold_ret = 0; inject_err = 0; ret_now = 0; req_on = '{0, 0};
    pend = -1; starve = 0; err = 0;

    // reset state, with both masters requesting and a stray return
    reset_n = 1'b0;
    m0_read = 1'b1; m0_address = 29'h0abc_1234; m0_burstcount = 8'd3;
    m1_read = 1'b1; m1_address = 29'h1555_0001; m1_burstcount = 8'd2;
    s_waitrequest = 1'b0; s_readdatavalid = 1'b1; s_readdata = 64'h0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_s_read", 64'(s_read), 64'(0));
    check_eq("rst_m0_waitrequest", 64'(m0_waitrequest), 64'(1));
    check_eq("rst_m1_waitrequest", 64'(m1_waitrequest), 64'(1));
    check_eq("rst_m0_readdatavalid", 64'(m0_readdatavalid), 64'(0));
    check_eq("rst_m1_readdatavalid", 64'(m1_readdatavalid), 64'(0));
    check_eq("rst_outstanding", 64'(outstanding), 64'(0));
    check_eq("rst_error", 64'(error), 64'(0));
    check_eq("rst_s_address", 64'(s_address), 64'(29'h0abc_1234));
    check_eq("rst_s_burstcount", 64'(s_burstcount), 64'(3));
    s_readdatavalid = 1'b0; m0_read = 1'b0; m1_read = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // port-0 stream: 20 single reads, data 3 cycles after accept
    quota[0] = 20; bc_fix[0] = 1; lat_fix = 3;
    cnt0 = 0; cnt1 = 0; peak = 0; k = 0;
    while ((quota[0] != 0 || req_on[0] || exp_q.size() > 0) && k < 200) begin
      step();
      k++;
      cnt0 += int'(obs_rdv0);
      cnt1 += int'(obs_rdv1);
      if (int'(obs_out) > peak) peak = int'(obs_out);
    end
    check_eq("stream_done", 64'(k < 200), 64'(1));
    check_eq("stream_m0_pulses", 64'(cnt0), 64'(20));
    check_eq("stream_m1_pulses", 64'(cnt1), 64'(0));
    check_eq("stream_peak", 64'(peak), 64'(3));
    run_until_idle("stream_drain", 100);

    // contention: both held, m1 must win every 9th accept
    quota = '{-1, -1}; bc_fix = '{1, 1}; lat_fix = 1;
    got = 0; k = 0;
    while (got < 27 && k < 200) begin
      step();
      k++;
      if (!obs_w0 || !obs_w1) begin
        seq[got] = !obs_w1;
        got++;
      end
    end
    check_eq("starve_done", 64'(got), 64'(27));
    for (int i = 0; i < 27; i++) check_eq("starve_seq", 64'(seq[i]), 64'(i % 9 == 8));
    run_until_idle("starve_drain", 200);

    // lock: m1 stalled 4 cycles while m0 rises
    quota[1] = 1; wait_hold = 4;
    step();
    a1 = req_addr[1];
    check_eq("lock_addr", 64'(obs_addr), 64'(a1));
    check_eq("lock_w1_stall", 64'(obs_w1), 64'(1));
    quota[0] = 1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check_eq("lock_addr", 64'(obs_addr), 64'(a1));
      check_eq("lock_w1_stall", 64'(obs_w1), 64'(1));
      check_eq("lock_w0_stall", 64'(obs_w0), 64'(1));
    end
    step();
    check_eq("lock_addr_accept", 64'(obs_addr), 64'(a1));
    check_eq("lock_w1_accept", 64'(obs_w1), 64'(0));
    check_eq("lock_w0_wait", 64'(obs_w0), 64'(1));
    step();
    check_eq("lock_w0_next", 64'(obs_w0), 64'(0));
    check_eq("lock_addr_next", 64'(obs_addr), 64'(req_addr[0]));
    run_until_idle("lock_drain", 100);

    // bursts: m0 x4, m1 x2, m0 burstcount 0, returned back to back
    hold_ret = 1;
    bc_fix[0] = 4; quota[0] = 1; wait_accept(0, "burst_acc_a");
    bc_fix[1] = 2; quota[1] = 1; wait_accept(1, "burst_acc_b");
    bc_fix[0] = 0; quota[0] = 1; wait_accept(0, "burst_acc_c");
    hold_ret = 0; p_ret = 100;
    for (int i = 0; i < 7; i++) begin
      step();
      check_eq("burst_rdv0", 64'(obs_rdv0), 64'(i < 4 || i == 6));
      check_eq("burst_rdv1", 64'(obs_rdv1), 64'(i == 4 || i == 5));
    end
    step();
    check_eq("burst_outstanding", 64'(obs_out), 64'(0));
    run_until_idle("burst_drain", 50);

    // full FIFO: 16 accepts with no data returned
    hold_ret = 1; quota = '{-1, -1}; bc_fix = '{1, 1}; k = 0;
    while (exp_q.size() < DEPTH && k < 60) begin
      step();
      k++;
    end
    check_eq("full_reached", 64'(exp_q.size()), 64'(DEPTH));
    step();
    check_eq("full_s_read", 64'(obs_sread), 64'(0));
    check_eq("full_w0", 64'(obs_w0), 64'(1));
    check_eq("full_w1", 64'(obs_w1), 64'(1));
    check_eq("full_outstanding", 64'(obs_out), 64'(16));
    hold_ret = 0; p_ret = 100;
    step();
    check_eq("full_first_return", 64'(obs_rdv0 | obs_rdv1), 64'(1));
    check_eq("full_s_read_pop", 64'(obs_sread), 64'(0));
    step();
    check_eq("full_s_read_reassert", 64'(obs_sread), 64'(1));
    run_until_idle("full_drain", 200);

    // randomized traffic
    for (int blk = 0; blk < 15; blk++) begin
      quota = '{-1, -1}; bc_fix = '{-1, -1}; lat_fix = 0;
      p_req[0] = int'($urandom_range(0, 100));
      p_req[1] = int'($urandom_range(0, 100));
      p_wait   = int'($urandom_range(0, 50));
      p_ret    = int'($urandom_range(20, 100));
      hold_ret = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < 100; i++) step();
    end
    p_req = '{100, 100}; lat_fix = 1;
    run_until_idle("random_drain", 2000);

    // spurious return with empty FIFO
    inject_err = 1;
    step();
    inject_err = 0;
    check_eq("err_rdv0", 64'(obs_rdv0), 64'(0));
    check_eq("err_rdv1", 64'(obs_rdv1), 64'(0));
    step();
    check_eq("err_sticky", 64'(obs_err), 64'(1));

    // reset mid-burst
    bc_fix[0] = 4; quota[0] = 1; wait_accept(0, "rst_acc");
    cnt0 = 0; k = 0;
    while (cnt0 < 2 && k < 20) begin
      step();
      k++;
      cnt0 += int'(obs_rdv0);
    end
    check_eq("rst_words_before", 64'(cnt0), 64'(2));
    m0_read = 1'b1; m0_address = 29'($urandom()); m0_burstcount = 8'd1;
    s_readdatavalid = 1'b0;
    #1;
    check_eq("pre_rst_s_read", 64'(s_read), 64'(1));
    check_eq("pre_rst_outstanding", 64'(outstanding), 64'(1));
    check_eq("pre_rst_error", 64'(error), 64'(1));
    reset_n = 1'b0;
    #1;
    check_eq("midrst_s_read", 64'(s_read), 64'(0));
    check_eq("midrst_m0_waitrequest", 64'(m0_waitrequest), 64'(1));
    check_eq("midrst_outstanding", 64'(outstanding), 64'(0));
    check_eq("midrst_error", 64'(error), 64'(0));
    req_on = '{0, 0}; quota = '{0, 0}; m0_read = 1'b0;
    exp_q.delete(); pend = -1; starve = 0; err = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    // the two words still owed by the slave arrive with no tag
    run_until_idle("post_rst_drain", 50);
    check_eq("post_rst_error", 64'(obs_err), 64'(1));
    check_eq("post_rst_outstanding", 64'(obs_out), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
